// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-port OBI memory arbiter.
package obi_arb_pkg;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_IDX_INSTR = 1'b0;
  localparam arb_id_t ARB_IDX_DATA  = 1'b1;

  function automatic logic [1:0] arb_onehot(input arb_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding transactions.
// Pointers wrap modulo DEPTH; a push and a pop together leave the count unchanged.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output arb_id_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  arb_id_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= push_id;
        wr_ptr_q      <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-requester (instr/data) OBI arbiter onto one memory port with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (data first).
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0]                       m_req_i,
  output logic [1:0]                       m_gnt_o,
  output logic [1:0]                       m_rvalid_o,
  input  logic [1:0][ADDR_WIDTH-1:0]       m_addr_i,
  input  logic [1:0]                       m_we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]     m_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]       m_wdata_i,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             s_req_o,
  input  logic                             s_gnt_i,
  input  logic                             s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic [DATA_WIDTH-1:0]            s_rdata_i
);

  arb_id_t win;
  arb_id_t lock_id_q;
  logic    lock_q;
  logic    handshake;
  logic    pop;
  logic    fifo_full;
  logic    fifo_empty;
  arb_id_t fifo_head;

`ifdef ARB_ROUND_ROBIN_EN
  arb_id_t last_q;
`endif

  // A stalled request keeps its winner so the downstream address stays stable until granted.
  always_comb begin
    win = ARB_IDX_INSTR;
    if (lock_q) begin
      win = lock_id_q;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (&m_req_i) begin
      win = ~last_q;
`endif
    end else if (m_req_i[ARB_IDX_DATA]) begin
      win = ARB_IDX_DATA;
    end
  end

  assign s_req_o   = m_req_i[win] & ~fifo_full & ~rst_i;
  assign handshake = s_req_o & s_gnt_i;
  assign s_addr_o  = m_addr_i[win];
  assign s_we_o    = m_we_i[win];
  assign s_be_o    = m_be_i[win];
  assign s_wdata_o = m_wdata_i[win];
  assign m_gnt_o   = handshake ? arb_onehot(win) : 2'b00;

  assign pop        = s_rvalid_i & ~fifo_empty & ~rst_i;
  assign m_rvalid_o = pop ? arb_onehot(fifo_head) : 2'b00;
  assign m_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= ARB_IDX_INSTR;
    end else if (s_req_o & ~s_gnt_i) begin
      lock_q    <= 1'b1;
      lock_id_q <= win;
    end else if (handshake) begin
      lock_q    <= 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= ARB_IDX_DATA;
    end else if (handshake) begin
      last_q <= win;
    end
  end
`endif

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (handshake),
    .push_id (win),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench for obi_mem_arbiter: expected requester IDs are queued at each grant
// and popped when a response is presented.
module tb_obi_mem_arbiter;

  localparam logic [31:0] ADDR_INSTR  = 32'h0001_0000;
  localparam logic [31:0] ADDR_DATA   = 32'h0002_0000;
  localparam logic [31:0] WDATA_INSTR = 32'hCAFE_0000;
  localparam logic [31:0] WDATA_DATA  = 32'hBEEF_0001;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       m_req_i;
  logic [1:0]       m_gnt_o;
  logic [1:0]       m_rvalid_o;
  logic [1:0][31:0] m_addr_i;
  logic [1:0]       m_we_i;
  logic [1:0][3:0]  m_be_i;
  logic [1:0][31:0] m_wdata_i;
  logic [31:0]      m_rdata_o;
  logic             s_req_o;
  logic             s_gnt_i;
  logic             s_rvalid_i;
  logic [31:0]      s_addr_o;
  logic             s_we_o;
  logic [3:0]       s_be_o;
  logic [31:0]      s_wdata_o;
  logic [31:0]      s_rdata_i;

  int testsRun    = 0;
  int testsFailed = 0;
  bit expQ[$];

  obi_mem_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_rvalid_o (m_rvalid_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_rvalid_i (s_rvalid_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rdata_i  (s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then advance past the edge.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic expSreq,
                               input logic expWin, input string tag);
    logic [1:0] expRvalid;
    logic [1:0] expGnt;
    bit         id;
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rdata;
    #3;
    expRvalid = 2'b00;
    if (rv && expQ.size() > 0) begin
      id        = expQ.pop_front();
      expRvalid = id ? 2'b10 : 2'b01;
    end
    expGnt = (expSreq && gnt) ? (expWin ? 2'b10 : 2'b01) : 2'b00;
    checkOutput({tag, "_sreq"},   32'(s_req_o),    32'(expSreq));
    checkOutput({tag, "_gnt"},    32'(m_gnt_o),    32'(expGnt));
    checkOutput({tag, "_rvalid"}, 32'(m_rvalid_o), 32'(expRvalid));
    checkOutput({tag, "_rdata"},  m_rdata_o,       rdata);
    if (expSreq) begin
      checkOutput({tag, "_addr"},  s_addr_o,       expWin ? ADDR_DATA : ADDR_INSTR);
      checkOutput({tag, "_we"},    32'(s_we_o),    32'(expWin));
      checkOutput({tag, "_wdata"}, s_wdata_o,      expWin ? WDATA_DATA : WDATA_INSTR);
      checkOutput({tag, "_be"},    32'(s_be_o),    expWin ? 32'hC : 32'h3);
    end
    if (expSreq && gnt) expQ.push_back(expWin);
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyReset(input logic [1:0] req, input logic rv, input string tag);
    rst_i      = 1'b1;
    m_req_i    = req;
    s_gnt_i    = 1'b1;
    s_rvalid_i = rv;
    s_rdata_i  = 32'h5555_AAAA;
    #3;
    checkOutput({tag, "_sreq"},   32'(s_req_o),    32'h0);
    checkOutput({tag, "_gnt"},    32'(m_gnt_o),    32'h0);
    checkOutput({tag, "_rvalid"}, 32'(m_rvalid_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    expQ.delete();
  endtask

  initial begin
    bit w;
    m_addr_i[0]  = ADDR_INSTR;
    m_addr_i[1]  = ADDR_DATA;
    m_wdata_i[0] = WDATA_INSTR;
    m_wdata_i[1] = WDATA_DATA;
    m_we_i       = 2'b10;
    m_be_i[0]    = 4'h3;
    m_be_i[1]    = 4'hC;

    applyReset(2'b11, 1'b1, "reset");

    // Single zero-wait request, response two cycles later.
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, "single_gnt");
    applyStimulus(2'b00, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, "single_idle");
    applyStimulus(2'b00, 1'b1, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, "single_rsp");
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, "empty_rsp");

    // Both requesting with a response every cycle.
    applyReset(2'b00, 1'b0, "reset2");
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = (i % 2) == 1;
`else
      w = 1'b1;
`endif
      applyStimulus(2'b11, 1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b1, w, "both_req");
    end
    applyStimulus(2'b00, 1'b0, 1'b1, 32'hA000_0010, 1'b0, 1'b0, "both_drain");

    // Lock on wait, then FIFO-full stall and in-order response routing.
    applyReset(2'b00, 1'b0, "reset3");
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, "lock_c0");
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, "lock_c1");
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, "lock_c2");
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, "lock_gnt");
    applyStimulus(2'b10, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, "data_gnt");
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, "full_stall");
    applyStimulus(2'b01, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, "full_pop");
    applyStimulus(2'b01, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b0, "refill");
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, "last_rsp");
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, "stray_rsp");

    // Reset while a request is outstanding drops its response.
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, "mid_gnt");
    applyReset(2'b01, 1'b1, "mid_reset");
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, "post_reset_rsp");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
